axis_upscaler_arb: RTL and testbench
====================================

AXIS_UPSCALER_ARB -- requirements
Module: axis_upscaler_arb

Interface
REQ-001 Parameter IMG_RES_Y, default 0, lines per frame; 0 SHALL raise an elaboration $error.
REQ-002 Parameter WDT_CYCLES, default 65536, watchdog stall limit in cycles; used only with the macro in REQ-019.
REQ-003 axis_aclk  in  1  sole clock; every register SHALL be updated on the rising edge.
REQ-004 axis_areset  in  1  reset, synchronous and active-high.
REQ-005 s0_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  requester 0 pixel stream; tuser marks start of frame (SOF), tlast marks end of line (EOL).
REQ-006 s1_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  requester 1 stream, same semantics.
REQ-007 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  shared stream to the nearest-neighbour upscaler.
REQ-008 grant  out  2  one-hot owner; 2'b00 when idle.
REQ-009 sync_err  out  1  one-cycle pulse on any framing error.

Function
REQ-010 FSM states: IDLE, BUSY0, BUSY1.
REQ-011 IDLE: m_axis_tvalid SHALL be 0. A port with tvalid=1 and tuser=0 SHALL have tready=1, and that beat SHALL be discarded (resync). A port with tvalid=1 and tuser=1 is a request; its tready SHALL be 0.
REQ-012 Arbitration in IDLE is round-robin:
- single request: that port wins;
- both requesting: the port not granted last wins;
- transition to BUSYn occurs on the next edge.
REQ-013 BUSYn: m_axis tdata/tvalid/tlast/tuser SHALL equal sn_axis combinationally, and sn_axis_tready SHALL equal m_axis_tready (zero latency). The other port's tready SHALL be 0.
REQ-014 Line counter (width clog2(IMG_RES_Y)) SHALL increment on each m_axis handshake with tlast=1.
- Handshake with tlast=1 at count IMG_RES_Y-1: counter SHALL clear, FSM SHALL return to IDLE, and last_grant SHALL update to n.
REQ-015 A handshake with tuser=1 in BUSYn at line count != 0, or at line count 0 after at least one beat of the frame has been accepted (premature SOF):
- sync_err SHALL pulse;
- line counter SHALL reset to 0 and the frame SHALL restart;
- grant SHALL be kept;
- the beat SHALL pass through.
REQ-016 First-to-last grant latency: request seen at cycle N, grant valid and first beat presentable at cycle N+1.
REQ-017 grant SHALL be a registered decode of the FSM state.

Reset
REQ-018 While axis_areset=1, on the clock edge: FSM IDLE; line counter 0; last_grant=1 (port 0 wins the first tie); watchdog counter 0; sync_err 0. All tready, m_axis_tvalid and grant SHALL be 0 during reset. Reset mid-frame SHALL abandon the frame with no flush.

Configuration
REQ-019 Macro AXIS_UPS_ARB_WDT_EN defined: in BUSYn, a counter SHALL count consecutive cycles with no m_axis handshake and clear on each handshake.
- On reaching WDT_CYCLES-1: FSM SHALL go to IDLE, line counter SHALL clear, last_grant=n, and sync_err SHALL pulse.
- Any remaining beats of that port SHALL be discarded per REQ-011 until the next SOF.
REQ-020 Macro undefined: no watchdog logic; BUSYn SHALL persist indefinitely until frame end.

Verification
REQ-021 IMG_RES_Y=4, s0 only, 4 lines x 3 beats, SOF on the first beat, m_axis_tready=1 -> grant=01 one cycle after the request; 12 beats out unchanged; IDLE after the 4th tlast; sync_err never asserted.
REQ-022 s0 and s1 both request SOF in the same cycle after reset -> s0 frame first (grant=01), then grant=10 for the s1 frame; the next simultaneous request goes to s0.
REQ-023 IDLE, s1 sends 5 non-SOF beats then SOF -> 5 beats accepted and dropped with m_axis_tvalid=0; grant=10 follows the SOF.
REQ-024 BUSY0, tuser=1 arriving at line 2 -> sync_err pulses for 1 cycle; counter restarts; 4 further tlast handshakes are required before IDLE.
REQ-025 WDT_EN, WDT_CYCLES=16, s0 stops mid-frame -> after 16 idle cycles: grant=00, sync_err pulse, pending s1 SOF granted next cycle. Without the macro -> grant stays 01.
REQ-026 axis_areset asserted for 1 cycle at line 2 of BUSY1 -> next cycle: grant=00, all tready=0, then normal arbitration with port 0 preferred.

Source files
------------

// File: rtl/axis_upscaler_arb_if.sv
// -----------------------------------------------------------------------------
// axis_upscaler_arb_if
// Purpose : 8-bit AXI4-Stream pixel bus used by the upscaler arbiter.
//           tuser marks the start of a frame (SOF), tlast marks end of line.
// Signals : tdata[7:0], tvalid, tready, tlast, tuser
// Modports: master - drives tdata/tvalid/tlast/tuser, receives tready
//           slave  - receives tdata/tvalid/tlast/tuser, drives tready
// -----------------------------------------------------------------------------
interface axis_upscaler_arb_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_upscaler_arb.sv
// -----------------------------------------------------------------------------
// axis_upscaler_arb
// Purpose : Round-robin, frame-granular arbiter that lets two pixel streams
//           share one nearest-neighbour upscaler input. A port owns the output
//           from its SOF beat until the tlast of line IMG_RES_Y-1. While idle,
//           non-SOF beats are swallowed so a port can resynchronise on the next
//           SOF. A premature SOF restarts the frame and pulses sync_err.
// Ports   : axis_aclk   - clock
//           axis_areset - synchronous, active-high reset
//           s0_axis     - requester 0 stream (slave modport)
//           s1_axis     - requester 1 stream (slave modport)
//           m_axis      - shared output stream (master modport)
//           grant[1:0]  - one-hot current owner, 2'b00 when idle (registered)
//           sync_err    - one-cycle pulse on a framing error
// Params  : IMG_RES_Y   - lines per frame (must be non-zero)
//           WDT_CYCLES  - stall limit of the optional watchdog
// Macro   : AXIS_UPS_ARB_WDT_EN - when defined, a port that stops handshaking
//           for WDT_CYCLES cycles mid-frame loses its grant.
// -----------------------------------------------------------------------------
module axis_upscaler_arb #(
    parameter int IMG_RES_Y  = 0,
    parameter int WDT_CYCLES = 65536
) (
    input  logic                       axis_aclk,
    input  logic                       axis_areset,
    axis_upscaler_arb_if.slave         s0_axis,
    axis_upscaler_arb_if.slave         s1_axis,
    axis_upscaler_arb_if.master        m_axis,
    output logic [1:0]                 grant,
    output logic                       sync_err
);
    localparam int             LCW       = (IMG_RES_Y > 1) ? $clog2(IMG_RES_Y) : 1;
    localparam logic [LCW-1:0] LAST_LINE = LCW'(IMG_RES_Y - 1);

    generate
        if (IMG_RES_Y == 0) begin : g_bad_res
            $error("axis_upscaler_arb: IMG_RES_Y must be non-zero");
        end
        if (WDT_CYCLES < 2) begin : g_bad_wdt
            $error("axis_upscaler_arb: WDT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] lineCnt_q, lineCnt_d;
    logic           beatSeen_q, beatSeen_d;
    logic           lastGrant_q, lastGrant_d;
    logic [1:0]     grant_q;
    logic           syncErr_q, syncErr_d;

    logic           req0, req1;
    logic [7:0]     srcData;
    logic           srcValid, srcLast, srcUser;
    logic           handshake, frameErr, frameEnd;
    logic [LCW-1:0] baseLine;

`ifdef AXIS_UPS_ARB_WDT_EN
    localparam int            WW       = $clog2(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
    logic [WW-1:0] wdtCnt_q, wdtCnt_d;
`endif

    // Select the owning port's beat; nothing is forwarded while idle.
    always_comb begin
        srcData  = '0;
        srcValid = 1'b0;
        srcLast  = 1'b0;
        srcUser  = 1'b0;
        if (state_q == BUSY0) begin
            srcData  = s0_axis.tdata;
            srcValid = s0_axis.tvalid;
            srcLast  = s0_axis.tlast;
            srcUser  = s0_axis.tuser;
        end else if (state_q == BUSY1) begin
            srcData  = s1_axis.tdata;
            srcValid = s1_axis.tvalid;
            srcLast  = s1_axis.tlast;
            srcUser  = s1_axis.tuser;
        end
    end

    // Next-state, line tracking and handshake steering.
    // A tuser beat counts as premature once any beat of the current frame has
    // been accepted; the restarted frame begins with that very beat, so the
    // beat still counts toward the new frame (including its own tlast).
    always_comb begin
        state_d     = state_q;
        lineCnt_d   = lineCnt_q;
        beatSeen_d  = beatSeen_q;
        lastGrant_d = lastGrant_q;
        syncErr_d   = 1'b0;
        frameErr    = 1'b0;
        frameEnd    = 1'b0;
        baseLine    = lineCnt_q;
        req0        = s0_axis.tvalid & s0_axis.tuser;
        req1        = s1_axis.tvalid & s1_axis.tuser;
        handshake   = srcValid & m_axis.tready;

        m_axis.tdata   = srcData;
        m_axis.tvalid  = srcValid & ~axis_areset;
        m_axis.tlast   = srcLast;
        m_axis.tuser   = srcUser;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
`ifdef AXIS_UPS_ARB_WDT_EN
        wdtCnt_d = '0;
`endif

        case (state_q)
            IDLE: begin
                s0_axis.tready = s0_axis.tvalid & ~s0_axis.tuser;
                s1_axis.tready = s1_axis.tvalid & ~s1_axis.tuser;
                lineCnt_d      = '0;
                beatSeen_d     = 1'b0;
                // lastGrant_q holds the port that finished most recently.
                if (req0 && req1) begin
                    state_d = lastGrant_q ? BUSY0 : BUSY1;
                end else if (req0) begin
                    state_d = BUSY0;
                end else if (req1) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (state_q == BUSY0) begin
                    s0_axis.tready = m_axis.tready;
                end else begin
                    s1_axis.tready = m_axis.tready;
                end
                if (handshake) begin
                    beatSeen_d = 1'b1;
                    frameErr   = srcUser & ((lineCnt_q != '0) | beatSeen_q);
                    baseLine   = frameErr ? '0 : lineCnt_q;
                    syncErr_d  = frameErr;
                    lineCnt_d  = baseLine;
                    if (srcLast) begin
                        if (baseLine == LAST_LINE) begin
                            frameEnd = 1'b1;
                        end else begin
                            lineCnt_d = baseLine + LCW'(1);
                        end
                    end
                end
`ifdef AXIS_UPS_ARB_WDT_EN
                else if (wdtCnt_q == WDT_LAST) begin
                    frameEnd  = 1'b1;
                    syncErr_d = 1'b1;
                end else begin
                    wdtCnt_d = wdtCnt_q + WW'(1);
                end
`endif
                if (frameEnd) begin
                    state_d     = IDLE;
                    lineCnt_d   = '0;
                    beatSeen_d  = 1'b0;
                    lastGrant_d = (state_q == BUSY1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (axis_areset) begin
            s0_axis.tready = 1'b0;
            s1_axis.tready = 1'b0;
        end
    end

    // State registers; grant is decoded from the next state so it lines up
    // with the state register itself.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q     <= IDLE;
            lineCnt_q   <= '0;
            beatSeen_q  <= 1'b0;
            lastGrant_q <= 1'b1;
            grant_q     <= 2'b00;
            syncErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lineCnt_q   <= lineCnt_d;
            beatSeen_q  <= beatSeen_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= {state_d == BUSY1, state_d == BUSY0};
            syncErr_q   <= syncErr_d;
        end
    end

`ifdef AXIS_UPS_ARB_WDT_EN
    // Consecutive no-handshake cycles of the current owner.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wdtCnt_q <= '0;
        end else begin
            wdtCnt_q <= wdtCnt_d;
        end
    end
`endif

    assign grant    = grant_q;
    assign sync_err = syncErr_q;
endmodule

// File: tb/tb_axis_upscaler_arb.sv
// -----------------------------------------------------------------------------
// tb_axis_upscaler_arb
// Purpose : Self-checking bench for axis_upscaler_arb (IMG_RES_Y=4,
//           WDT_CYCLES=16). Frames are generated as beat lists; the expected
//           output is the concatenation of whole frames in round-robin order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_upscaler_arb;
    localparam int IMG_RES_Y  = 4;
    localparam int WDT_CYCLES = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [1:0] g;
    } outrec_t;

    logic       clock;
    logic       reset;
    logic [1:0] grant;
    logic       sync_err;

    axis_upscaler_arb_if s0If ();
    axis_upscaler_arb_if s1If ();
    axis_upscaler_arb_if mIf ();

    axis_upscaler_arb #(
        .IMG_RES_Y (IMG_RES_Y),
        .WDT_CYCLES(WDT_CYCLES)
    ) dut (
        .axis_aclk  (clock),
        .axis_areset(reset),
        .s0_axis    (s0If),
        .s1_axis    (s1If),
        .m_axis     (mIf),
        .grant      (grant),
        .sync_err   (sync_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int      vectors = 0;
    int      miscompares = 0;
    beat_t   srcQ0[$];
    beat_t   srcQ1[$];
    outrec_t stage0[$];
    outrec_t stage1[$];
    outrec_t outQ[$];
    outrec_t expQ[$];
    bit      hold0, hold1, gaps, randReady, prevErr;
    int      drop0, drop1, errPulses, errLong, idleValid;
    int      modelLast;

    // Round-robin reference: ties go to the port that did not finish last.
    function automatic int rrWinner(input bit r0, input bit r1);
        if (r0 && r1) return (modelLast == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic clearBoard();
        outQ.delete();
        expQ.delete();
        stage0.delete();
        stage1.delete();
        drop0 = 0; drop1 = 0; errPulses = 0; errLong = 0; idleValid = 0;
        prevErr = 1'b0;
    endtask

    // Append one frame to a port's source queue and to its expected stage.
    // lineLen 0 gives random line lengths; sofAtLine>0 starts a complete new
    // frame at that line of the current one.
    task automatic pushFrame(input int port, input int lineLen, input int sofAtLine);
        int lines;
        lines = (sofAtLine > 0) ? sofAtLine + IMG_RES_Y : IMG_RES_Y;
        for (int l = 0; l < lines; l++) begin
            int len;
            len = (lineLen > 0) ? lineLen : int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) begin
                beat_t   b;
                outrec_t r;
                b.data = 8'($urandom);
                b.user = (k == 0) && (l == 0 || l == sofAtLine);
                b.last = (k == len - 1);
                r.b = b;
                r.g = (port == 0) ? 2'b01 : 2'b10;
                if (port == 0) begin
                    srcQ0.push_back(b);
                    stage0.push_back(r);
                end else begin
                    srcQ1.push_back(b);
                    stage1.push_back(r);
                end
            end
        end
    endtask

    task automatic moveStage(input int port);
        if (port == 0) begin
            foreach (stage0[i]) expQ.push_back(stage0[i]);
            stage0.delete();
        end else begin
            foreach (stage1[i]) expQ.push_back(stage1[i]);
            stage1.delete();
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later.
    task automatic applyStimulus();
        outrec_t r;
        @(negedge clock);
        if (!hold0) begin
            if (srcQ0.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                s0If.tdata = srcQ0[0].data; s0If.tlast = srcQ0[0].last;
                s0If.tuser = srcQ0[0].user; s0If.tvalid = 1'b1; hold0 = 1'b1;
            end else begin
                s0If.tvalid = 1'b0;
            end
        end
        if (!hold1) begin
            if (srcQ1.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                s1If.tdata = srcQ1[0].data; s1If.tlast = srcQ1[0].last;
                s1If.tuser = srcQ1[0].user; s1If.tvalid = 1'b1; hold1 = 1'b1;
            end else begin
                s1If.tvalid = 1'b0;
            end
        end
        mIf.tready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (s0If.tvalid && s0If.tready) begin
            if (grant == 2'b00) drop0++;
            void'(srcQ0.pop_front());
            hold0 = 1'b0;
        end
        if (s1If.tvalid && s1If.tready) begin
            if (grant == 2'b00) drop1++;
            void'(srcQ1.pop_front());
            hold1 = 1'b0;
        end
        if (mIf.tvalid && mIf.tready) begin
            r.b.data = mIf.tdata; r.b.last = mIf.tlast; r.b.user = mIf.tuser; r.g = grant;
            outQ.push_back(r);
        end
        if (mIf.tvalid && grant == 2'b00) idleValid++;
        if (sync_err) begin
            errPulses++;
            if (prevErr) errLong++;
        end
        prevErr = sync_err;
    endtask

    task automatic drain(input int maxCycles, output bit timedOut);
        int n;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!(srcQ0.size() == 0 && srcQ1.size() == 0 && grant == 2'b00) && n < maxCycles);
        timedOut = !(srcQ0.size() == 0 && srcQ1.size() == 0 && grant == 2'b00);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        s0If.tvalid = 1'b0; s1If.tvalid = 1'b0; mIf.tready = 1'b1;
        srcQ0.delete(); srcQ1.delete(); hold0 = 1'b0; hold1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        modelLast = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s0If.tdata = 8'h00; s0If.tlast = 1'b0; s0If.tuser = 1'b0; s0If.tvalid = 1'b1;
        s1If.tdata = 8'h00; s1If.tlast = 1'b0; s1If.tuser = 1'b1; s1If.tvalid = 1'b1;
        mIf.tready = 1'b1;
        hold0 = 1'b0; hold1 = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant: got %b, expected 00", grant); end
        vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sync_err: got %b, expected 0", sync_err); end
        vectors++; if (s0If.tready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s0_tready: got %b, expected 0", s0If.tready); end
        vectors++; if (s1If.tready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s1_tready: got %b, expected 0", s1If.tready); end
        vectors++; if (mIf.tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_tvalid: got %b, expected 0", mIf.tvalid); end
        @(negedge clock);
        reset = 1'b0;
        s1If.tvalid = 1'b0;
        #1;
        vectors++; if (s0If.tready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_discard_ready: got %b, expected 1", s0If.tready); end
        s0If.tvalid = 1'b0;
        modelLast = 1;
    endtask

    task automatic test_single_frame();
        bit to;
        int bad;
        clearBoard();
        gaps = 1'b0; randReady = 1'b0;
        pushFrame(0, 3, 0);
        moveStage(rrWinner(1'b1, 1'b0));
        applyStimulus();
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL req_cycle_grant: got %b, expected 00", grant); end
        vectors++; if (s0If.tready !== 1'b0) begin miscompares++; $display("[TB] FAIL req_cycle_ready: got %b, expected 0", s0If.tready); end
        applyStimulus();
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("[TB] FAIL grant_latency: got %b, expected 01", grant); end
        vectors++; if (mIf.tvalid !== 1'b1 || mIf.tdata !== expQ[0].b.data) begin
            miscompares++; $display("[TB] FAIL first_beat: got v=%b d=%h, expected v=1 d=%h", mIf.tvalid, mIf.tdata, expQ[0].b.data);
        end
        drain(200, to);
        modelLast = 0;
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL single_idle: got grant %b, expected 00 after frame", grant); end
        bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
        vectors++; if (bad != 0 || outQ.size() != expQ.size()) begin
            miscompares++; $display("[TB] FAIL single_stream: got %0d beats (%0d differ), expected %0d", outQ.size(), bad, expQ.size());
        end
        vectors++; if (errPulses != 0) begin miscompares++; $display("[TB] FAIL single_sync_err: got %0d pulses, expected 0", errPulses); end
    endtask

    task automatic test_random_frames();
        bit to;
        int bad;
        clearBoard();
        gaps = 1'b1; randReady = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pushFrame(0, 0, 0);
            moveStage(0);
        end
        drain(2000, to);
        modelLast = 0;
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL random_timeout: got grant %b, expected 00", grant); end
        bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
        vectors++; if (bad != 0 || outQ.size() != expQ.size()) begin
            miscompares++; $display("[TB] FAIL random_stream: got %0d beats (%0d differ), expected %0d", outQ.size(), bad, expQ.size());
        end
        vectors++; if (errPulses != 0 || idleValid != 0) begin
            miscompares++; $display("[TB] FAIL random_framing: got %0d err pulses, %0d idle valids, expected 0/0", errPulses, idleValid);
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int bad, w;
        doReset();
        for (int round = 0; round < 2; round++) begin
            clearBoard();
            gaps = 1'b0; randReady = 1'b0;
            pushFrame(0, 0, 0);
            pushFrame(1, 0, 0);
            w = rrWinner(1'b1, 1'b1);
            moveStage(w);
            moveStage(1 - w);
            modelLast = 1 - w;
            drain(500, to);
            vectors++; if (to) begin miscompares++; $display("[TB] FAIL rr_timeout_%0d: got grant %b, expected 00", round, grant); end
            bad = 0;
            for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
            vectors++; if (bad != 0 || outQ.size() != expQ.size()) begin
                miscompares++; $display("[TB] FAIL rr_order_%0d: got %0d beats (%0d differ, first grant %b), expected %0d starting with %b",
                                        round, outQ.size(), bad, (outQ.size() > 0) ? outQ[0].g : 2'b00, expQ.size(), expQ[0].g);
            end
        end
    endtask

    task automatic test_resync();
        bit to;
        int bad;
        beat_t b;
        clearBoard();
        gaps = 1'b1; randReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b.data = 8'($urandom); b.user = 1'b0; b.last = 1'($urandom);
            srcQ1.push_back(b);
        end
        pushFrame(1, 0, 0);
        moveStage(rrWinner(1'b0, 1'b1));
        drain(500, to);
        modelLast = 1;
        vectors++; if (drop1 != 5) begin miscompares++; $display("[TB] FAIL resync_drops: got %0d, expected 5", drop1); end
        vectors++; if (idleValid != 0) begin miscompares++; $display("[TB] FAIL resync_idle_valid: got %0d, expected 0", idleValid); end
        bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
        vectors++; if (to || bad != 0 || outQ.size() != expQ.size()) begin
            miscompares++; $display("[TB] FAIL resync_stream: got %0d beats (%0d differ, timeout %b), expected %0d", outQ.size(), bad, to, expQ.size());
        end
    endtask

    task automatic test_premature_sof();
        bit to;
        int bad;
        clearBoard();
        gaps = 1'b1; randReady = 1'b1;
        pushFrame(0, 0, 2);
        moveStage(0);
        drain(1000, to);
        modelLast = 0;
        bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
        vectors++; if (to || bad != 0 || outQ.size() != expQ.size()) begin
            miscompares++; $display("[TB] FAIL sof_restart_stream: got %0d beats (%0d differ, timeout %b), expected %0d", outQ.size(), bad, to, expQ.size());
        end
        vectors++; if (errPulses != 1 || errLong != 0) begin
            miscompares++; $display("[TB] FAIL sof_sync_err: got %0d pulses (%0d extended), expected 1 single-cycle", errPulses, errLong);
        end
    endtask

    task automatic test_watchdog();
        int held, n;
        bit to;
        int bad;
        beat_t b;
        outrec_t r;
        doReset();
        clearBoard();
        gaps = 1'b0; randReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b.data = 8'($urandom); b.user = (k == 0); b.last = (k == 2);
            srcQ0.push_back(b);
            r.b = b; r.g = 2'b01;
            expQ.push_back(r);
        end
        pushFrame(1, 0, 0);
        n = 0;
        while (srcQ0.size() != 0 && n < 50) begin applyStimulus(); n++; end
        held = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (grant != 2'b01) break;
            held++;
        end
`ifdef AXIS_UPS_ARB_WDT_EN
        vectors++; if (held != WDT_CYCLES || grant !== 2'b00) begin
            miscompares++; $display("[TB] FAIL wdt_release: got grant %b after %0d cycles, expected 00 after %0d", grant, held, WDT_CYCLES);
        end
        vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("[TB] FAIL wdt_sync_err: got %b, expected 1", sync_err); end
        applyStimulus();
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("[TB] FAIL wdt_next_grant: got %b, expected 10", grant); end
        moveStage(1);
        drain(500, to);
        modelLast = 1;
        bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
        vectors++; if (to || bad != 0 || outQ.size() != expQ.size()) begin
            miscompares++; $display("[TB] FAIL wdt_stream: got %0d beats (%0d differ, timeout %b), expected %0d", outQ.size(), bad, to, expQ.size());
        end
`else
        vectors++; if (held != 40 || grant !== 2'b01) begin
            miscompares++; $display("[TB] FAIL stall_hold: got grant %b after %0d cycles, expected 01 for 40", grant, held);
        end
        vectors++; if (outQ.size() != 3 || s1If.tready !== 1'b0) begin
            miscompares++; $display("[TB] FAIL stall_s1_blocked: got %0d beats, s1 tready %b, expected 3 and 0", outQ.size(), s1If.tready);
        end
        vectors++; if (errPulses != 0) begin miscompares++; $display("[TB] FAIL stall_sync_err: got %0d pulses, expected 0", errPulses); end
`endif
    endtask

    task automatic test_reset_midframe();
        int n, lasts, bad, w;
        bit to;
        doReset();
        clearBoard();
        gaps = 1'b0; randReady = 1'b0;
        pushFrame(1, 3, 0);
        n = 0; lasts = 0;
        while (lasts < 2 && n < 100) begin
            applyStimulus();
            n++;
            lasts = 0;
            foreach (outQ[i]) if (outQ[i].b.last) lasts++;
        end
        vectors++; if (lasts != 2 || grant !== 2'b10) begin
            miscompares++; $display("[TB] FAIL midframe_setup: got %0d lines, grant %b, expected 2 and 10", lasts, grant);
        end
        @(negedge clock);
        reset = 1'b1;
        s0If.tvalid = 1'b1; s0If.tuser = 1'b0; s1If.tvalid = 1'b1; mIf.tready = 1'b1;
        #1;
        vectors++; if (s0If.tready !== 1'b0 || s1If.tready !== 1'b0 || mIf.tvalid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midframe_reset_outputs: got rdy0=%b rdy1=%b mvalid=%b, expected 0/0/0", s0If.tready, s1If.tready, mIf.tvalid);
        end
        @(negedge clock);
        reset = 1'b0;
        s0If.tvalid = 1'b0; s1If.tvalid = 1'b0;
        srcQ0.delete(); srcQ1.delete(); hold0 = 1'b0; hold1 = 1'b0;
        modelLast = 1;
        #1;
        vectors++; if (grant !== 2'b00 || s0If.tready !== 1'b0 || s1If.tready !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midframe_after_reset: got grant %b rdy %b%b, expected 00 00", grant, s0If.tready, s1If.tready);
        end
        clearBoard();
        pushFrame(0, 0, 0);
        pushFrame(1, 0, 0);
        w = rrWinner(1'b1, 1'b1);
        moveStage(w);
        moveStage(1 - w);
        modelLast = 1 - w;
        drain(500, to);
        bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) if (outQ[i] !== expQ[i]) bad++;
        vectors++; if (to || bad != 0 || outQ.size() != expQ.size()) begin
            miscompares++; $display("[TB] FAIL midframe_rearb: got %0d beats (%0d differ, timeout %b), expected %0d", outQ.size(), bad, to, expQ.size());
        end
    endtask

    initial begin
        $display("[TB] axis_upscaler_arb bench start");
        test_reset();
        test_single_frame();
        test_random_frames();
        test_round_robin();
        test_resync();
        test_premature_sof();
        test_watchdog();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
